// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. A request is
// accepted in IDLE, its operands are held in registers that drive the ALU,
// the ALU result is captured one cycle later (EXEC), and the result is
// presented to the granted requester until it is consumed (RESP).
// Simultaneous requests are served alternately, starting with port 0.
//
// Ports:
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_reqN_valid/o_reqN_ready   request handshake (ready is a 1-cycle pulse)
//   i_reqN_a/_b/_func           operands and function code of requester N
//   o_rspN_valid/i_rspN_ready   response handshake for requester N
//   o_rspN_c/o_rspN_ovf         result and overflow flag for requester N
//   o_alu_a/_b/_func            registered drive to the shared ALU
//   i_alu_c/i_alu_ovf           ALU result and overflow flag
//   o_busy                      high whenever the FSM is not IDLE
//   o_ovf_count                 saturating count of overflowed operations
// -----------------------------------------------------------------------------
package alu_arbiter_pkg;
    localparam int         WORD_SIZE = 16;
    localparam logic [2:0] FUNC_ADD  = 3'd0;
    localparam logic [2:0] FUNC_SUB  = 3'd1;
    localparam logic [2:0] FUNC_AND  = 3'd2;
    localparam logic [2:0] FUNC_OR   = 3'd3;
    localparam logic [2:0] FUNC_XOR  = 3'd4;
    localparam logic [2:0] FUNC_NOT  = 3'd5;
    localparam logic [2:0] FUNC_SHL  = 3'd6;
    localparam logic [2:0] FUNC_SHR  = 3'd7;
endpackage

module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req0_valid,
    output logic                 o_req0_ready,
    input  logic [WORD_SIZE-1:0] i_req0_a,
    input  logic [WORD_SIZE-1:0] i_req0_b,
    input  logic [2:0]           i_req0_func,
    output logic                 o_rsp0_valid,
    input  logic                 i_rsp0_ready,
    output logic [WORD_SIZE-1:0] o_rsp0_c,
    output logic                 o_rsp0_ovf,
    input  logic                 i_req1_valid,
    output logic                 o_req1_ready,
    input  logic [WORD_SIZE-1:0] i_req1_a,
    input  logic [WORD_SIZE-1:0] i_req1_b,
    input  logic [2:0]           i_req1_func,
    output logic                 o_rsp1_valid,
    input  logic                 i_rsp1_ready,
    output logic [WORD_SIZE-1:0] o_rsp1_c,
    output logic                 o_rsp1_ovf,
    output logic [WORD_SIZE-1:0] o_alu_a,
    output logic [WORD_SIZE-1:0] o_alu_b,
    output logic [2:0]           o_alu_func,
    input  logic [WORD_SIZE-1:0] i_alu_c,
    input  logic                 i_alu_ovf,
    output logic                 o_busy,
    output logic [7:0]           o_ovf_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_gnt;
    logic                 r_last_gnt;
    logic [WORD_SIZE-1:0] r_op_a;
    logic [WORD_SIZE-1:0] r_op_b;
    logic [2:0]           r_op_func;
    logic [WORD_SIZE-1:0] r_res_c;
    logic                 r_res_ovf;
    logic [7:0]           r_ovf_count;

    logic [1:0]           w_req_valid;
    logic [1:0]           w_rsp_ready;
    logic [1:0]           w_req_ready;
    logic [1:0]           w_rsp_valid;
    logic                 w_gnt_sel;
    logic                 w_any_req;
    logic                 w_rsp_done;

    assign w_req_valid = {i_req1_valid, i_req0_valid};
    assign w_rsp_ready = {i_rsp1_ready, i_rsp0_ready};
    assign w_any_req   = |w_req_valid;

    // With both ports requesting, the port that was not served last wins;
    // otherwise the single requester wins (port 1 iff it is the requester).
    assign w_gnt_sel   = (&w_req_valid) ? ~r_last_gnt : i_req1_valid;

    // Only the granted port's ready can complete a response.
    assign w_rsp_done  = w_rsp_ready[r_gnt];

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req)  w_state_next = ST_EXEC;
            ST_EXEC:                 w_state_next = ST_RESP;
            ST_RESP: if (w_rsp_done) w_state_next = ST_IDLE;
            default:                 w_state_next = ST_IDLE;
        endcase
    end

    // Output decode. Ready is gated by reset so that a request presented
    // while reset is held is never acknowledged.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            always_comb begin
                w_req_ready[gi] = 1'b0;
                w_rsp_valid[gi] = 1'b0;
                if (r_state == ST_IDLE && !i_reset && w_req_valid[gi]
                        && (w_gnt_sel == gi[0])) begin
                    w_req_ready[gi] = 1'b1;
                end
                if (r_state == ST_RESP && r_gnt == gi[0]) begin
                    w_rsp_valid[gi] = 1'b1;
                end
            end
        end
    endgenerate

    always_comb begin
        o_busy = (r_state != ST_IDLE);
    end

    // Datapath and bookkeeping registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_gnt       <= 1'b0;
            r_last_gnt  <= 1'b1;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_func   <= '0;
            r_res_c     <= '0;
            r_res_ovf   <= 1'b0;
            r_ovf_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt     <= w_gnt_sel;
                        r_op_a    <= w_gnt_sel ? i_req1_a    : i_req0_a;
                        r_op_b    <= w_gnt_sel ? i_req1_b    : i_req0_b;
                        r_op_func <= w_gnt_sel ? i_req1_func : i_req0_func;
                    end
                end
                ST_EXEC: begin
                    r_res_c   <= i_alu_c;
                    r_res_ovf <= i_alu_ovf;
                    if (i_alu_ovf && r_ovf_count != 8'hFF) begin
                        r_ovf_count <= r_ovf_count + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_done) begin
                        r_last_gnt <= r_gnt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req0_ready = w_req_ready[0];
    assign o_req1_ready = w_req_ready[1];
    assign o_rsp0_valid = w_rsp_valid[0];
    assign o_rsp1_valid = w_rsp_valid[1];
    assign o_rsp0_c     = r_res_c;
    assign o_rsp1_c     = r_res_c;
    assign o_rsp0_ovf   = r_res_ovf;
    assign o_rsp1_ovf   = r_res_ovf;
    assign o_alu_a      = r_op_a;
    assign o_alu_b      = r_op_b;
    assign o_alu_func   = r_op_func;
    assign o_ovf_count  = r_ovf_count;

endmodule
